// File: rtl/servo_pkg.sv
// Shared definitions for the servo command scheduler: command width,
// scheduler state encoding and the default clamp / failsafe values.
// Optional slew limiting is selected elsewhere with the SERVO_SLEW_EN macro.
package servo_pkg;

   localparam int CMD_W = 10;

   localparam logic [CMD_W-1:0] DEFAULT_CMD_MAX      = 10'd1000;
   localparam logic [CMD_W-1:0] DEFAULT_FAILSAFE_CMD = 10'd0;
   localparam logic [CMD_W-1:0] DEFAULT_SLEW_STEP    = 10'd16;

   typedef enum logic {
      FS  = 1'b0,
      RUN = 1'b1
   } state_t;

endpackage

// File: rtl/servo_slew.sv
// One channel's slew step: moves the current command toward the target
// by no more than step_size. Only instantiated when SERVO_SLEW_EN is defined.
module servo_slew
   import servo_pkg::*;
(
   input  logic [CMD_W-1:0] cur_cmd,
   input  logic [CMD_W-1:0] target_cmd,
   input  logic [CMD_W-1:0] step_size,
   output logic [CMD_W-1:0] next_cmd
);

   // Land exactly on the target when it is within one step, otherwise take a full step toward it
   always_comb begin
      next_cmd = target_cmd;
      if (target_cmd > cur_cmd) begin
         if ((target_cmd - cur_cmd) > step_size) begin
            next_cmd = cur_cmd + step_size;
         end
      end else if ((cur_cmd - target_cmd) > step_size) begin
         next_cmd = cur_cmd - step_size;
      end
   end

endmodule

// File: rtl/servo_sched.sv
// Servo command scheduler: buffers host writes in a shadow bank and commits
// them to the servo generators at frame boundaries, falling back to a
// failsafe command when the host stops updating.
// Optional feature: define SERVO_SLEW_EN to rate-limit commits while running.
module servo_sched
   import servo_pkg::*;
#(
   parameter int               NCH            = 4,
   parameter int               TIMEOUT_FRAMES = 50,
   parameter logic [CMD_W-1:0] FAILSAFE_CMD   = DEFAULT_FAILSAFE_CMD,
   parameter logic [CMD_W-1:0] CMD_MAX        = DEFAULT_CMD_MAX,
   parameter logic [CMD_W-1:0] SLEW_STEP      = DEFAULT_SLEW_STEP
) (
   input  logic                     CLK,
   input  logic                     RST,
   input  logic                     WR_VALID,
   output logic                     WR_READY,
   input  logic [$clog2(NCH)-1:0]   WR_CH,
   input  logic [CMD_W-1:0]         WR_DATA,
   input  logic                     FRAME_TICK,
   output logic [NCH*CMD_W-1:0]     CMD_OUT,
   output logic                     FAILSAFE,
   output logic                     UPD
);

   localparam int               CNT_W     = $clog2(TIMEOUT_FRAMES + 1);
   localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_FRAMES);

   state_t           state;
   state_t           state_next;
   logic [NCH-1:0]   dirty;
   logic [NCH-1:0]   dirty_after;
   logic [CMD_W-1:0] shadow [NCH];
   logic [CMD_W-1:0] cmd_q  [NCH];
   logic [CMD_W-1:0] target [NCH];
   logic [CNT_W-1:0] frame_cnt;
   logic [CNT_W-1:0] cnt_inc;
   logic             commit;
   logic             timeout;
   logic             wr_fire;
   logic [CMD_W-1:0] wr_clamped;
   logic             upd_q;

   // Writes are refused during a frame tick so the shadow bank is stable while it is committed
   always_comb begin
      WR_READY   = !RST && !FRAME_TICK;
      wr_fire    = WR_VALID && WR_READY;
      wr_clamped = (WR_DATA > CMD_MAX) ? CMD_MAX : WR_DATA;
   end

   // Frame-tick decisions and next-state logic: a pending write always commits, otherwise count idle frames
   always_comb begin
      commit     = FRAME_TICK && (dirty != '0);
      cnt_inc    = frame_cnt + 1'b1;
      timeout    = FRAME_TICK && !commit && (state == RUN) && (cnt_inc == CNT_LIMIT);
      state_next = state;
      case (state)
         FS: begin
            if (commit) state_next = RUN;
         end
         RUN: begin
            if (commit)       state_next = RUN;
            else if (timeout) state_next = FS;
         end
         default: state_next = FS;
      endcase
   end

   // State register
   always_ff @(posedge CLK) begin
      if (RST) state <= FS;
      else     state <= state_next;
   end

`ifdef SERVO_SLEW_EN
   logic [CMD_W-1:0] slewed [NCH];

   for (genvar i = 0; i < NCH; i++) begin : g_slew
      servo_slew u_slew (
         .cur_cmd    (cmd_q[i]),
         .target_cmd (shadow[i]),
         .step_size  (SLEW_STEP),
         .next_cmd   (slewed[i])
      );
   end

   // While running, commits are rate-limited and channels still short of their shadow stay dirty
   always_comb begin
      for (int i = 0; i < NCH; i++) begin
         target[i]      = (state == RUN) ? slewed[i] : shadow[i];
         dirty_after[i] = (target[i] != shadow[i]);
      end
   end
`else
   // Every commit copies the shadow bank straight through, so nothing remains pending
   always_comb begin
      for (int i = 0; i < NCH; i++) begin
         target[i] = shadow[i];
      end
      dirty_after = '0;
   end
`endif

   // Datapath: shadow capture, commit to outputs, failsafe override and idle-frame counting
   always_ff @(posedge CLK) begin
      if (RST) begin
         for (int i = 0; i < NCH; i++) begin
            shadow[i] <= '0;
            cmd_q[i]  <= FAILSAFE_CMD;
         end
         dirty     <= '0;
         frame_cnt <= '0;
         upd_q     <= 1'b0;
      end else begin
         upd_q <= commit;
         if (commit) begin
            for (int i = 0; i < NCH; i++) begin
               cmd_q[i] <= target[i];
            end
            dirty     <= dirty_after;
            frame_cnt <= '0;
         end else begin
            if (timeout) begin
               for (int i = 0; i < NCH; i++) begin
                  cmd_q[i] <= FAILSAFE_CMD;
               end
            end
            if (FRAME_TICK && (state == RUN)) begin
               frame_cnt <= cnt_inc;
            end
            if (wr_fire) begin
               shadow[WR_CH] <= wr_clamped;
               dirty[WR_CH]  <= 1'b1;
            end
         end
      end
   end

   for (genvar i = 0; i < NCH; i++) begin : g_out
      assign CMD_OUT[i*CMD_W +: CMD_W] = cmd_q[i];
   end

   assign FAILSAFE = (state == FS);
   assign UPD      = upd_q;

endmodule

// File: tb/tb_servo_sched.sv
// Directed self-checking bench for servo_sched (default parameters).
// Build with SERVO_SLEW_EN defined to exercise the slew-limited commit path.
module tb_servo_sched;

   logic        CLK;
   logic        RST;
   logic        WR_VALID;
   logic        WR_READY;
   logic [1:0]  WR_CH;
   logic [9:0]  WR_DATA;
   logic        FRAME_TICK;
   logic [39:0] CMD_OUT;
   logic        FAILSAFE;
   logic        UPD;

   int checks   = 0;
   int failures = 0;

   servo_sched dut (
      .CLK        (CLK),
      .RST        (RST),
      .WR_VALID   (WR_VALID),
      .WR_READY   (WR_READY),
      .WR_CH      (WR_CH),
      .WR_DATA    (WR_DATA),
      .FRAME_TICK (FRAME_TICK),
      .CMD_OUT    (CMD_OUT),
      .FAILSAFE   (FAILSAFE),
      .UPD        (UPD)
   );

   // Free-running 10 ns clock
   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   // Hard stop in case something upstream stalls
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog got=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic logic [9:0] chan(input int i);
      return CMD_OUT[i*10 +: 10];
   endfunction

   // Advance to just after the next rising edge
   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic applyReset();
      RST = 1'b1;
      step();
      step();
      RST = 1'b0;
   endtask

   task automatic applyWrite(input logic [1:0] ch, input logic [9:0] data);
      WR_VALID = 1'b1;
      WR_CH    = ch;
      WR_DATA  = data;
      step();
      WR_VALID = 1'b0;
   endtask

   task automatic applyTick();
      FRAME_TICK = 1'b1;
      step();
      FRAME_TICK = 1'b0;
   endtask

   task automatic test_reset();
      RST = 1'b1;
      step();
      step();
      checks++; if (WR_READY !== 1'b0) begin failures++; $display("[TB] FAIL reset_ready got=%0b expected=0", WR_READY); end
      checks++; if (CMD_OUT !== 40'd0) begin failures++; $display("[TB] FAIL reset_cmd got=%h expected=0", CMD_OUT); end
      checks++; if (FAILSAFE !== 1'b1) begin failures++; $display("[TB] FAIL reset_failsafe got=%0b expected=1", FAILSAFE); end
      checks++; if (UPD !== 1'b0) begin failures++; $display("[TB] FAIL reset_upd got=%0b expected=0", UPD); end
      RST = 1'b0;
      #1;
      checks++; if (WR_READY !== 1'b1) begin failures++; $display("[TB] FAIL ready_after_reset got=%0b expected=1", WR_READY); end
   endtask

   task automatic test_basic_commit();
      applyWrite(2'd2, 10'd500);
      checks++; if (chan(2) !== 10'd0) begin failures++; $display("[TB] FAIL precommit_ch2 got=%0d expected=0", chan(2)); end
      applyTick();
      checks++; if (chan(2) !== 10'd500) begin failures++; $display("[TB] FAIL commit_ch2 got=%0d expected=500", chan(2)); end
      checks++; if (UPD !== 1'b1) begin failures++; $display("[TB] FAIL commit_upd got=%0b expected=1", UPD); end
      checks++; if (FAILSAFE !== 1'b0) begin failures++; $display("[TB] FAIL commit_failsafe got=%0b expected=0", FAILSAFE); end
      checks++; if (chan(0) !== 10'd0 || chan(1) !== 10'd0 || chan(3) !== 10'd0) begin failures++; $display("[TB] FAIL commit_others got=%h expected=%h", CMD_OUT, {10'd0, 10'd500, 10'd0, 10'd0}); end
      step();
      checks++; if (UPD !== 1'b0) begin failures++; $display("[TB] FAIL upd_width got=%0b expected=0", UPD); end
      checks++; if (chan(2) !== 10'd500) begin failures++; $display("[TB] FAIL hold_ch2 got=%0d expected=500", chan(2)); end
   endtask

   task automatic test_ready_block();
      WR_VALID   = 1'b1;
      WR_CH      = 2'd1;
      WR_DATA    = 10'd321;
      FRAME_TICK = 1'b1;
      #1;
      checks++; if (WR_READY !== 1'b0) begin failures++; $display("[TB] FAIL ready_on_tick got=%0b expected=0", WR_READY); end
      step();
      FRAME_TICK = 1'b0;
      #1;
      checks++; if (WR_READY !== 1'b1) begin failures++; $display("[TB] FAIL ready_after_tick got=%0b expected=1", WR_READY); end
      step();
      WR_VALID = 1'b0;
      checks++; if (chan(1) !== 10'd0) begin failures++; $display("[TB] FAIL blocked_not_committed got=%0d expected=0", chan(1)); end
      checks++; if (UPD !== 1'b0) begin failures++; $display("[TB] FAIL idle_tick_upd got=%0b expected=0", UPD); end
      applyTick();
      checks++; if (chan(1) !== 10'd321) begin failures++; $display("[TB] FAIL late_write_commit got=%0d expected=321", chan(1)); end
      checks++; if (UPD !== 1'b1) begin failures++; $display("[TB] FAIL late_write_upd got=%0b expected=1", UPD); end
      step();
   endtask

   task automatic test_clamp();
      applyWrite(2'd3, 10'd1023);
      applyWrite(2'd0, 10'd1000);
      applyTick();
      checks++; if (chan(3) !== 10'd1000) begin failures++; $display("[TB] FAIL clamp_1023 got=%0d expected=1000", chan(3)); end
      checks++; if (chan(0) !== 10'd1000) begin failures++; $display("[TB] FAIL clamp_edge got=%0d expected=1000", chan(0)); end
      checks++; if (chan(2) !== 10'd500 || chan(1) !== 10'd321) begin failures++; $display("[TB] FAIL clamp_others got=%h expected=%h", CMD_OUT, {10'd1000, 10'd500, 10'd321, 10'd1000}); end
      step();
   endtask

   task automatic test_timeout();
      for (int t = 0; t < 49; t++) begin
         applyTick();
         step();
      end
      checks++; if (FAILSAFE !== 1'b0) begin failures++; $display("[TB] FAIL no_timeout_49 got=%0b expected=0", FAILSAFE); end
      applyWrite(2'd0, 10'd10);
      applyTick();
      checks++; if (chan(0) !== 10'd10 || FAILSAFE !== 1'b0) begin failures++; $display("[TB] FAIL commit_at_49 got=%0d/%0b expected=10/0", chan(0), FAILSAFE); end
      step();
      for (int t = 0; t < 49; t++) begin
         applyTick();
         step();
      end
      checks++; if (FAILSAFE !== 1'b0 || chan(0) !== 10'd10) begin failures++; $display("[TB] FAIL still_run_49 got=%0b/%0d expected=0/10", FAILSAFE, chan(0)); end
      applyTick();
      checks++; if (FAILSAFE !== 1'b1) begin failures++; $display("[TB] FAIL timeout_50 got=%0b expected=1", FAILSAFE); end
      checks++; if (CMD_OUT !== 40'd0) begin failures++; $display("[TB] FAIL timeout_cmd got=%h expected=0", CMD_OUT); end
      checks++; if (UPD !== 1'b0) begin failures++; $display("[TB] FAIL timeout_upd got=%0b expected=0", UPD); end
      step();
      applyTick();
      checks++; if (FAILSAFE !== 1'b1 || CMD_OUT !== 40'd0 || UPD !== 1'b0) begin failures++; $display("[TB] FAIL fs_idle_tick got=%0b/%h/%0b expected=1/0/0", FAILSAFE, CMD_OUT, UPD); end
      step();
      // Leaving failsafe restores every channel from its shadow, not just the written one
      applyWrite(2'd1, 10'd77);
      applyTick();
      checks++; if (CMD_OUT !== {10'd1000, 10'd500, 10'd77, 10'd10}) begin failures++; $display("[TB] FAIL fs_exit_all got=%h expected=%h", CMD_OUT, {10'd1000, 10'd500, 10'd77, 10'd10}); end
      checks++; if (FAILSAFE !== 1'b0 || UPD !== 1'b1) begin failures++; $display("[TB] FAIL fs_exit_flags got=%0b/%0b expected=0/1", FAILSAFE, UPD); end
      step();
   endtask

   task automatic test_slew();
      applyReset();
      applyWrite(2'd0, 10'd100);
      applyTick();
      checks++; if (chan(0) !== 10'd100) begin failures++; $display("[TB] FAIL slew_from_fs got=%0d expected=100", chan(0)); end
      step();
      applyWrite(2'd0, 10'd200);
`ifdef SERVO_SLEW_EN
      for (int k = 1; k <= 7; k++) begin
         logic [9:0] expCmd;
         expCmd = (k == 7) ? 10'd200 : 10'(100 + 16 * k);
         applyTick();
         checks++; if (chan(0) !== expCmd || UPD !== 1'b1) begin failures++; $display("[TB] FAIL slew_tick%0d got=%0d/%0b expected=%0d/1", k, chan(0), UPD, expCmd); end
         step();
      end
      applyTick();
      checks++; if (chan(0) !== 10'd200 || UPD !== 1'b0) begin failures++; $display("[TB] FAIL slew_settled got=%0d/%0b expected=200/0", chan(0), UPD); end
      step();
      applyWrite(2'd0, 10'd150);
      applyTick();
      checks++; if (chan(0) !== 10'd184) begin failures++; $display("[TB] FAIL slew_down got=%0d expected=184", chan(0)); end
      step();
      applyReset();
      applyWrite(2'd0, 10'd200);
      applyTick();
      checks++; if (chan(0) !== 10'd200 || FAILSAFE !== 1'b0) begin failures++; $display("[TB] FAIL slew_fs_immediate got=%0d/%0b expected=200/0", chan(0), FAILSAFE); end
      step();
`else
      applyTick();
      checks++; if (chan(0) !== 10'd200 || UPD !== 1'b1) begin failures++; $display("[TB] FAIL direct_commit got=%0d/%0b expected=200/1", chan(0), UPD); end
      step();
      applyTick();
      checks++; if (UPD !== 1'b0) begin failures++; $display("[TB] FAIL direct_no_repeat got=%0b expected=0", UPD); end
      step();
`endif
   endtask

   task automatic test_reset_discard();
      applyWrite(2'd1, 10'd300);
      applyReset();
      applyTick();
      checks++; if (chan(1) !== 10'd0 || CMD_OUT !== 40'd0) begin failures++; $display("[TB] FAIL discard_cmd got=%h expected=0", CMD_OUT); end
      checks++; if (UPD !== 1'b0) begin failures++; $display("[TB] FAIL discard_upd got=%0b expected=0", UPD); end
      checks++; if (FAILSAFE !== 1'b1) begin failures++; $display("[TB] FAIL discard_failsafe got=%0b expected=1", FAILSAFE); end
      step();
      checks++; if (UPD !== 1'b0) begin failures++; $display("[TB] FAIL discard_upd_late got=%0b expected=0", UPD); end
   endtask

   task automatic test_back_to_back();
      applyWrite(2'd2, 10'd100);
      applyWrite(2'd2, 10'd200);
      applyWrite(2'd3, 10'd50);
      applyTick();
      checks++; if (CMD_OUT !== {10'd50, 10'd200, 10'd0, 10'd0}) begin failures++; $display("[TB] FAIL overwrite got=%h expected=%h", CMD_OUT, {10'd50, 10'd200, 10'd0, 10'd0}); end
      checks++; if (UPD !== 1'b1 || FAILSAFE !== 1'b0) begin failures++; $display("[TB] FAIL overwrite_flags got=%0b/%0b expected=1/0", UPD, FAILSAFE); end
      step();
   endtask

   // Run every scenario in order, then report
   initial begin
      RST        = 1'b1;
      WR_VALID   = 1'b0;
      WR_CH      = 2'd0;
      WR_DATA    = 10'd0;
      FRAME_TICK = 1'b0;
      test_reset();
      test_basic_commit();
      test_ready_block();
      test_clamp();
      test_timeout();
      test_slew();
      test_reset_discard();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/servo_sched.md
SERVO_SCHED -- requirements
Module: servo_sched

Interface
Parameters:
REQ-001 The block SHALL have parameter NCH, default 4, meaning the number of servo channels.
REQ-002 The block SHALL have parameter TIMEOUT_FRAMES, default 50, meaning the number of frames without a commit before failsafe.
REQ-003 The block SHALL have parameter FAILSAFE_CMD, default 10'd0, meaning the command driven on all channels in failsafe.
REQ-004 The block SHALL have parameter CMD_MAX, default 10'd1000, meaning the write-data clamp ceiling.
REQ-005 The block SHALL have parameter SLEW_STEP, default 10'd16, meaning the maximum per-frame change per channel (used only when slew limiting is compiled in).
Ports:
REQ-006 The block SHALL have port CLK, input, 1 bit: the single clock.
REQ-007 The block SHALL have port RST, input, 1 bit: reset, synchronous and active-high.
REQ-008 The block SHALL have port WR_VALID, input, 1 bit: a host command write is offered.
REQ-009 The block SHALL have port WR_READY, output, 1 bit: the write is accepted when WR_VALID and WR_READY are both high.
REQ-010 The block SHALL have port WR_CH, input, $clog2(NCH) bits: the target channel.
REQ-011 The block SHALL have port WR_DATA, input, 10 bits: the requested command.
REQ-012 The block SHALL have port FRAME_TICK, input, 1 bit: a 1-cycle pulse at each servo PWM period start.
REQ-013 The block SHALL have port CMD_OUT, output, NCH*10 bits: the committed commands, channel i at bits [10i+9:10i], feeding the per-channel servo generators.
REQ-014 The block SHALL have port FAILSAFE, output, 1 bit: high while in state FS.
REQ-015 The block SHALL have port UPD, output, 1 bit: a 1-cycle pulse after each commit.

Function
REQ-016 Each accepted write SHALL store min(WR_DATA, CMD_MAX) into shadow[WR_CH] and set dirty[WR_CH]; a later write to the same channel before commit SHALL overwrite it.
REQ-017 WR_READY SHALL be low in the cycle FRAME_TICK is high and high otherwise (outside reset), so no write can race a commit.
REQ-018 The FSM SHALL have states FS (failsafe) and RUN.
REQ-019 On FRAME_TICK with dirty != 0, the block SHALL, in either state, commit: CMD_OUT <= target per channel, dirty <= 0, frame_cnt <= 0, UPD = 1 in the following cycle, state <= RUN.
REQ-020 In the commit, channels with dirty cleared SHALL also take shadow, which holds their last value.
REQ-021 On FRAME_TICK with dirty == 0 in RUN, frame_cnt SHALL increment; when the incremented value equals TIMEOUT_FRAMES, the state SHALL go to FS and all CMD_OUT channels SHALL be set to FAILSAFE_CMD in the same edge.
REQ-022 In FS, frame_cnt SHALL hold, and FRAME_TICK with dirty == 0 SHALL change nothing.
REQ-023 CMD_OUT SHALL change only on a FRAME_TICK edge or on reset; latency from a write to CMD_OUT SHALL be 1 cycle after the next FRAME_TICK that follows acceptance.
REQ-024 frame_cnt SHALL be $clog2(TIMEOUT_FRAMES+1) bits wide and SHALL never wrap.

Reset
REQ-025 While RST is high at a CLK edge, the block SHALL set state=FS, FAILSAFE=1, CMD_OUT all FAILSAFE_CMD, shadow all 0, dirty=0, frame_cnt=0, UPD=0, and WR_READY=0.
REQ-026 Reset asserted mid-operation SHALL discard pending dirty writes, and no UPD pulse SHALL follow.

Configuration
REQ-027 Macro SERVO_SLEW_EN: when defined, the commit in RUN→RUN SHALL move each channel from CMD_OUT toward shadow by at most SLEW_STEP, and dirty bits SHALL stay set for channels not yet reaching shadow, so the next frames keep committing.
REQ-028 Macro SERVO_SLEW_EN: a commit from FS and the transition into FS SHALL be immediate, with no slew.
REQ-029 Without SERVO_SLEW_EN, every commit SHALL copy shadow directly and the SLEW_STEP logic SHALL be absent.

Structure
REQ-030 Package servo_pkg SHALL hold CMD_W=10, the state enum (FS, RUN), and the CMD_MAX and FAILSAFE_CMD defaults.
REQ-031 The block SHALL contain one sub-module, servo_slew: a per-channel combinational step toward target, instantiated NCH times under SERVO_SLEW_EN.

Verification
REQ-032 The bench SHALL check: after reset, CMD_OUT=0 on all channels and FAILSAFE=1; write ch2=500, then FRAME_TICK → ch2=500 one cycle later, UPD=1 for 1 cycle, FAILSAFE=0.
REQ-033 The bench SHALL check: WR_VALID held across a FRAME_TICK cycle → WR_READY=0 in that cycle, the write accepted in the next cycle, and the commit applied at the next FRAME_TICK.
REQ-034 The bench SHALL check: WR_DATA=1023 → shadow and CMD_OUT=1000.
REQ-035 The bench SHALL check: in RUN, 50 FRAME_TICKs with no writes → FAILSAFE=1 and all channels=0 at the 50th tick; 49 ticks then a write → no failsafe.
REQ-036 The bench SHALL check: with SERVO_SLEW_EN and RUN at ch0=100, write 200 → ch0=116, 132, … reaching 200 on the 7th tick, with UPD on each tick; the same write from FS → 200 immediately.
REQ-037 The bench SHALL check: write ch1=300, then RST pulse before FRAME_TICK → after the tick, ch1=0, no UPD pulse, and FAILSAFE=1.
